// File: rtl/crt_grid_render_if.sv
// Solver-side port of the CRT grid renderer: back-buffer pixel writes and buffer-swap handshake.
interface crt_grid_render_if;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic       wr_data;
  logic       swap_req;
  logic       swap_pending;
  logic       swap_done;

  modport master (
    output wr_en, wr_addr, wr_data, swap_req,
    input  swap_pending, swap_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, swap_req,
    output swap_pending, swap_done
  );
endinterface

// File: rtl/crt_grid_render.sv
// Converts 480p raster position into RGB444 from a double-buffered 40x6 CRT image,
// with a two-stage colour pipeline and matching sync/data-enable delay.
module crt_grid_render #(
  parameter logic [11:0] ON_COLOR   = 12'h0F0,
  parameter logic [11:0] OFF_COLOR  = 12'h020,
  parameter bit          GRID_LINES = 1'b0,
  parameter logic [11:0] GRID_COLOR = 12'h000
) (
  input  logic                 clk_pix,
  input  logic                 rst_pix_n,
  input  logic [9:0]           sx,
  input  logic [9:0]           sy,
  input  logic                 de,
  input  logic                 hsync,
  input  logic                 vsync,
  crt_grid_render_if.slave     fb_if,
  output logic [3:0]           vga_r,
  output logic [3:0]           vga_g,
  output logic [3:0]           vga_b,
  output logic                 hsync_o,
  output logic                 vsync_o,
  output logic                 de_o
);

  localparam int unsigned PIX_W     = 10;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned ROW_W     = 3;
  localparam int unsigned RGB_W     = 12;
  localparam int unsigned COLS      = 40;
  localparam int unsigned ROWS      = 6;
  localparam int unsigned CELLS     = COLS * ROWS;
  localparam int unsigned ROW_H     = 80;
  localparam int unsigned SWAP_LINE = 480;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } swap_state_t;

  swap_state_t           state;
  logic                  front_sel;
  logic                  swap_pending_q;
  logic                  swap_done_q;
  logic [CELLS-1:0]      fb [2];

  logic [ROW_W-1:0]      row_c;
  logic [PIX_W-1:0]      row_base_c;
  logic                  row_found_c;
  logic [PIX_W-1:0]      yoff_c;
  logic [ADDR_W-1:0]     idx_c;
  logic                  border_c;

  logic [ADDR_W-1:0]     idx_s1;
  logic                  border_s1;
  logic                  de_s1;
  logic                  hsync_s1;
  logic                  vsync_s1;

  logic                  pix_on_c;
  logic [RGB_W-1:0]      color_c;
  logic [RGB_W-1:0]      rgb_q;

  logic                  swap_pt_c;
  logic                  wr_ok_c;

  // Row = floor(sy/80) by comparing against the row boundaries; row_base_c = row*80.
  always_comb begin
    row_c       = ROW_W'(ROWS);
    row_base_c  = PIX_W'(ROWS * ROW_H);
    row_found_c = 1'b0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (!row_found_c && (sy < PIX_W'((r + 1) * ROW_H))) begin
        row_c       = ROW_W'(r);
        row_base_c  = PIX_W'(r * ROW_H);
        row_found_c = 1'b1;
      end
    end
  end

  assign yoff_c   = sy - row_base_c;
  // row*40 = row*32 + row*8; only meaningful inside the active area.
  assign idx_c    = ADDR_W'({row_c, 5'b0_0000}) + ADDR_W'({row_c, 3'b000}) + ADDR_W'(sx[9:4]);
  assign border_c = GRID_LINES && ((sx[3:0] == 4'd0) || (yoff_c == PIX_W'(0)));

  // Stage 1: cell index, border flag and raw timing.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      idx_s1    <= '0;
      border_s1 <= 1'b0;
      de_s1     <= 1'b0;
      hsync_s1  <= 1'b1;
      vsync_s1  <= 1'b1;
    end else begin
      idx_s1    <= idx_c;
      border_s1 <= border_c;
      de_s1     <= de;
      hsync_s1  <= hsync;
      vsync_s1  <= vsync;
    end
  end

  assign pix_on_c = (idx_s1 < ADDR_W'(CELLS)) ? fb[front_sel][idx_s1] : 1'b0;

  always_comb begin
    color_c = '0;
    if (de_s1) begin
      if (border_s1)     color_c = GRID_COLOR;
      else if (pix_on_c) color_c = ON_COLOR;
      else               color_c = OFF_COLOR;
    end
  end

  // Stage 2: colour plus delayed syncs.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      rgb_q   <= '0;
      de_o    <= 1'b0;
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
    end else begin
      rgb_q   <= color_c;
      de_o    <= de_s1;
      hsync_o <= hsync_s1;
      vsync_o <= vsync_s1;
    end
  end

  assign vga_r = rgb_q[11:8];
  assign vga_g = rgb_q[7:4];
  assign vga_b = rgb_q[3:0];

  assign swap_pt_c = (sx == PIX_W'(0)) && (sy == PIX_W'(SWAP_LINE));
  assign wr_ok_c   = fb_if.wr_en && (fb_if.wr_addr < ADDR_W'(CELLS));

  // Back-buffer writes use the pre-swap front_sel, so a swap-point write lands in the new front.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      fb[0] <= '0;
      fb[1] <= '0;
    end else if (wr_ok_c) begin
      fb[~front_sel][fb_if.wr_addr] <= fb_if.wr_data;
    end
  end

  // Swap control: arm on request, toggle at the start of vertical blanking.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state          <= ST_IDLE;
      front_sel      <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_done_q    <= 1'b0;
    end else begin
      swap_done_q <= 1'b0;
      if (swap_pt_c && ((state == ST_ARMED) || fb_if.swap_req)) begin
        front_sel      <= ~front_sel;
        state          <= ST_IDLE;
        swap_pending_q <= 1'b0;
        swap_done_q    <= 1'b1;
      end else if (fb_if.swap_req) begin
        state          <= ST_ARMED;
        swap_pending_q <= 1'b1;
      end
    end
  end

  assign fb_if.swap_pending = swap_pending_q;
  assign fb_if.swap_done    = swap_done_q;

endmodule

// File: tb/tb_crt_grid_render.sv
// Randomized bench for crt_grid_render: drives raster positions, writes and swaps into two
// instances (grid off / grid on) and compares against a frame-level reference model.
module tb_crt_grid_render;

  localparam logic [11:0] ON_C   = 12'h0F0;
  localparam logic [11:0] OFF_C  = 12'h020;
  localparam logic [11:0] GRID_C = 12'h000;

  logic       clk_pix   = 1'b0;
  logic       rst_pix_n = 1'b0;
  logic [9:0] sx        = 10'd799;
  logic [9:0] sy        = 10'd524;
  logic       de        = 1'b0;
  logic       hsync     = 1'b1;
  logic       vsync     = 1'b1;

  logic [3:0] r0, g0, b0, r1, g1, b1;
  logic       hs0, vs0, de0, hs1, vs1, de1;

  crt_grid_render_if if0 ();
  crt_grid_render_if if1 ();

  crt_grid_render #(.ON_COLOR(ON_C), .OFF_COLOR(OFF_C), .GRID_LINES(1'b0), .GRID_COLOR(GRID_C)) dut0 (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(sx), .sy(sy), .de(de), .hsync(hsync), .vsync(vsync),
    .fb_if(if0), .vga_r(r0), .vga_g(g0), .vga_b(b0), .hsync_o(hs0), .vsync_o(vs0), .de_o(de0)
  );

  crt_grid_render #(.ON_COLOR(ON_C), .OFF_COLOR(OFF_C), .GRID_LINES(1'b1), .GRID_COLOR(GRID_C)) dut1 (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(sx), .sy(sy), .de(de), .hsync(hsync), .vsync(vsync),
    .fb_if(if1), .vga_r(r1), .vga_g(g1), .vga_b(b1), .hsync_o(hs1), .vsync_o(vs1), .de_o(de1)
  );

  always #5 clk_pix = ~clk_pix;

  int errs   = 0;
  int checks = 0;
  int hs_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t sx=%0d sy=%0d)", tag, got, exp, $time, sx, sy);
    end
  endtask

  // Reference model: two 240-pixel images, which one is shown, and whether a swap is armed.
  bit fb_m [2][240];
  int front_m;
  bit armed_m;
  bit pend_e;
  bit done_e;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [11:0] rgb0;
    logic [11:0] rgb1;
  } exp_t;

  exp_t hist [2];

  function automatic logic [11:0] exp_pix(input int x, input int y, input bit grid);
    if (!(x < 640 && y < 480)) return 12'h000;
    if (grid && ((x % 16 == 0) || (y % 80 == 0))) return GRID_C;
    return fb_m[front_m][(y / 80) * 40 + x / 16] ? ON_C : OFF_C;
  endfunction

  task automatic drive_if(input bit we, input int wa, input bit wd, input bit sr);
    if0.wr_en = we; if0.wr_addr = 8'(wa); if0.wr_data = wd; if0.swap_req = sr;
    if1.wr_en = we; if1.wr_addr = 8'(wa); if1.wr_data = wd; if1.swap_req = sr;
  endtask

  // One pixel clock: check what the DUTs show now, then present the next input and advance the model.
  task automatic cyc(input int x, input int y, input bit we, input int wa, input bit wd, input bit sr);
    exp_t e;
    bit   de_n, hs_n, vs_n;
    @(negedge clk_pix);
    chk("rgb0", 32'({r0, g0, b0}), 32'(hist[1].rgb0));
    chk("rgb1", 32'({r1, g1, b1}), 32'(hist[1].rgb1));
    chk("sync0", 32'({de0, hs0, vs0}), 32'({hist[1].de, hist[1].hs, hist[1].vs}));
    chk("sync1", 32'({de1, hs1, vs1}), 32'({hist[1].de, hist[1].hs, hist[1].vs}));
    chk("pend0", 32'(if0.swap_pending), 32'(pend_e));
    chk("pend1", 32'(if1.swap_pending), 32'(pend_e));
    chk("done0", 32'(if0.swap_done), 32'(done_e));
    chk("done1", 32'(if1.swap_done), 32'(done_e));
    if (!hs0) hs_cnt++;

    de_n = (x < 640) && (y < 480);
    hs_n = !(x >= 656 && x < 752);
    vs_n = !(y >= 490 && y < 492);
    sx = 10'(x); sy = 10'(y); de = de_n; hsync = hs_n; vsync = vs_n;
    drive_if(we, wa, wd, sr);

    e.de = de_n; e.hs = hs_n; e.vs = vs_n;
    e.rgb0 = exp_pix(x, y, 1'b0);
    e.rgb1 = exp_pix(x, y, 1'b1);
    hist[1] = hist[0];
    hist[0] = e;

    if (we && wa < 240) fb_m[1 - front_m][wa] = wd;
    done_e = 1'b0;
    if (x == 0 && y == 480 && (armed_m || sr)) begin
      front_m = 1 - front_m;
      armed_m = 1'b0;
      done_e  = 1'b1;
    end else if (sr) begin
      armed_m = 1'b1;
    end
    pend_e = armed_m;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(799, 524, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic rand_pix(input int n, input bit rwr, input int sr_pm);
    for (int i = 0; i < n; i++) begin
      int x, y, wa;
      bit we, wd, sr;
      if ($urandom_range(0, 7) == 0) begin
        x = int'($urandom_range(0, 799)); y = int'($urandom_range(0, 524));
      end else begin
        x = int'($urandom_range(0, 639)); y = int'($urandom_range(0, 479));
      end
      we = rwr && ($urandom_range(0, 3) == 0);
      wa = int'($urandom_range(0, 255));
      wd = 1'($urandom_range(0, 1));
      sr = (int'($urandom_range(0, 999)) < sr_pm);
      cyc(x, y, we, wa, wd, sr);
    end
  endtask

  task automatic corner_scan();
    int xs [9] = '{0, 15, 16, 17, 623, 624, 639, 640, 799};
    int ys [10] = '{0, 1, 79, 80, 81, 399, 400, 479, 480, 524};
    foreach (ys[j]) foreach (xs[i]) begin
      if (!(xs[i] == 0 && ys[j] == 480)) cyc(xs[i], ys[j], 1'b0, 0, 1'b0, 1'b0);
    end
  endtask

  task automatic block_scan(input int x0, input int y0);
    for (int y = y0; y < y0 + 80; y++)
      for (int x = x0; x < x0 + 16; x++) cyc(x, y, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic swap_pt(input bit sr, input bit we, input int wa, input bit wd);
    cyc(0, 480, we, wa, wd, sr);
    idle(3);
  endtask

  task automatic line(input int y);
    idle(2);
    hs_cnt = 0;
    for (int x = 0; x < 800; x++) cyc(x, y, 1'b0, 0, 1'b0, 1'b0);
    idle(2);
    chk("hs_low_cycles", 32'(hs_cnt), 32'd96);
  endtask

  task automatic rst_chk();
    chk("rst_rgb0", 32'({r0, g0, b0}), 32'h0);
    chk("rst_rgb1", 32'({r1, g1, b1}), 32'h0);
    chk("rst_sync0", 32'({de0, hs0, vs0}), 32'b011);
    chk("rst_sync1", 32'({de1, hs1, vs1}), 32'b011);
    chk("rst_pend", 32'({if0.swap_pending, if1.swap_pending}), 32'b00);
    chk("rst_done", 32'({if0.swap_done, if1.swap_done}), 32'b00);
  endtask

  task automatic release_rst();
    exp_t r;
    @(negedge clk_pix);
    sx = 10'd799; sy = 10'd524; de = 1'b0; hsync = 1'b1; vsync = 1'b1;
    drive_if(1'b0, 0, 1'b0, 1'b0);
    rst_pix_n = 1'b1;
    foreach (fb_m[b, a]) fb_m[b][a] = 1'b0;
    front_m = 0; armed_m = 1'b0; pend_e = 1'b0; done_e = 1'b0;
    r.de = 1'b0; r.hs = 1'b1; r.vs = 1'b1; r.rgb0 = 12'h0; r.rgb1 = 12'h0;
    hist[0] = r;
    hist[1] = r;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_if(1'b0, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk_pix);
    #1;
    rst_chk();
    release_rst();

    // Blank image, full line for hsync width, random pixels, no swap.
    idle(2);
    line(10);
    rand_pix(1500, 1'b0, 0);
    corner_scan();
    swap_pt(1'b0, 1'b0, 0, 1'b0);

    // Light first and last cells, swap, scan both cell blocks.
    cyc(100, 100, 1'b1, 0, 1'b1, 1'b0);
    cyc(200, 300, 1'b1, 239, 1'b1, 1'b0);
    cyc(300, 200, 1'b0, 0, 1'b0, 1'b1);
    rand_pix(500, 1'b0, 0);
    swap_pt(1'b0, 1'b0, 0, 1'b0);
    block_scan(0, 0);
    block_scan(624, 400);
    rand_pix(800, 1'b0, 0);
    corner_scan();
    swap_pt(1'b0, 1'b0, 0, 1'b0);

    // Write without swap: three unchanged frames.
    cyc(50, 50, 1'b1, 41, 1'b1, 1'b0);
    for (int f = 0; f < 3; f++) begin
      rand_pix(800, 1'b0, 0);
      corner_scan();
      block_scan(16, 80);
      swap_pt(1'b0, 1'b0, 0, 1'b0);
    end

    // Double request mid-frame, plus request and write at the swap point.
    rand_pix(100, 1'b0, 0);
    cyc(320, 240, 1'b0, 0, 1'b0, 1'b1);
    rand_pix(100, 1'b0, 0);
    cyc(330, 250, 1'b0, 0, 1'b0, 1'b1);
    rand_pix(100, 1'b0, 0);
    swap_pt(1'b1, 1'b1, 5, 1'b1);
    block_scan(80, 0);
    block_scan(16, 80);
    corner_scan();

    // Out-of-range write must change nothing, then swap to expose both buffers.
    cyc(10, 10, 1'b1, 250, 1'b1, 1'b0);
    cyc(20, 20, 1'b1, 255, 1'b1, 1'b0);
    swap_pt(1'b1, 1'b0, 0, 1'b0);
    rand_pix(600, 1'b0, 0);
    corner_scan();
    swap_pt(1'b1, 1'b0, 0, 1'b0);
    rand_pix(600, 1'b0, 0);

    // Random writes and requests over several frames.
    for (int f = 0; f < 4; f++) begin
      rand_pix(2500, 1'b1, 3);
      corner_scan();
      swap_pt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 239)), 1'b1);
      rand_pix(1500, 1'b0, 0);
    end

    // Reset with a swap armed mid-frame.
    cyc(60, 60, 1'b1, 7, 1'b1, 1'b0);
    cyc(70, 70, 1'b0, 0, 1'b0, 1'b1);
    rand_pix(50, 1'b0, 0);
    #2;
    rst_pix_n = 1'b0;
    #1;
    rst_chk();
    repeat (3) @(posedge clk_pix);
    #1;
    rst_chk();
    release_rst();
    cyc(60, 60, 1'b1, 0, 1'b1, 1'b0);
    rand_pix(400, 1'b0, 0);
    corner_scan();
    swap_pt(1'b0, 1'b0, 0, 1'b0);
    block_scan(0, 0);
    swap_pt(1'b1, 1'b0, 0, 1'b0);
    block_scan(0, 0);
    rand_pix(400, 1'b0, 0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
